condicionador_entradas: RTL and testbench

CONDICIONADOR_ENTRADAS -- requirements
Module: condicionador_entradas

---
 rtl/condicionador_entradas.sv | 205 ++++++++++++++++++++
 tb/tb_condicionador_entradas.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_entradas.sv
// condicionador_entradas: conditions the raw button inputs of a menu panel.
// Each raw bit goes through a 2-FF synchronizer. The vertical pair, the horizontal
// pair and the confirm button are then debounced as separate channels. The block
// emits one-cycle step pulses for each axis and for the confirm button.
// Optional feature: define AUTOREPEAT_EN to add the per-axis hold-to-repeat FSMs.
module condicionador_entradas #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] controle_vertical,
    input  logic [1:0] controle_horizontal,
    input  logic       confirma,
    output logic [1:0] vertical_estavel,
    output logic [1:0] horizontal_estavel,
    output logic       pulso_vertical,
    output logic       pulso_horizontal,
    output logic       confirma_pulso,
    output logic [3:0] db_estado
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Channel index: 0 = vertical, 1 = horizontal, 2 = confirm (value in bit 0).
    logic [4:0]         sync1_q, sync2_q, prev_q;
    logic [2:0][1:0]    samp, samp_prev;
    logic [2:0][1:0]    deb_q, deb_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         ini;
    logic [1:0]         rep;
    logic               conf_ev;
    logic               pv_q, ph_q, pc_q;

    // A debounced 11 on a button pair is treated as neutral.
    function automatic logic [1:0] nivel(input logic [1:0] v);
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    assign samp      = {{1'b0, sync2_q[4]}, sync2_q[3:2], sync2_q[1:0]};
    assign samp_prev = {{1'b0, prev_q[4]},  prev_q[3:2],  prev_q[1:0]};

    // Two-flop synchronizer, plus the sample from the previous cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {confirma, controle_horizontal, controle_vertical};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Debounce: count a run of equal samples that differ from the stable value
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            if (samp[c] != deb_q[c]) begin
                // The count includes the current sample, so a run of N equal samples reads N.
                cnt_d[c] = (samp[c] != samp_prev[c]) ? CW'(1) : cnt_q[c] + CW'(1);
                if (cnt_d[c] == CW'(DEBOUNCE_CYCLES)) begin
                    deb_d[c] = samp[c];
                    cnt_d[c] = '0;
                end
            end
        end
    end

    // Debounced values and run counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Step events: an axis moves to a new non-neutral level, or confirm is pressed
    always_comb begin
        ini = '0;
        for (int unsigned a = 0; a < 2; a++) begin
            ini[a] = (nivel(deb_d[a]) != nivel(deb_q[a])) && (nivel(deb_d[a]) != 2'b00);
        end
        conf_ev = deb_d[2][0] & ~deb_q[2][0];
    end

`ifdef AUTOREPEAT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } rep_state_e;

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX);

    rep_state_e      st_q [2];
    rep_state_e      st_d [2];
    logic [RW-1:0]   rcnt_q [2];
    logic [RW-1:0]   rcnt_d [2];
    logic [1:0]      rep_raw;
    logic [1:0]      ini_next;
    logic [2:0][1:0] samp_next;

    assign samp_next = {{1'b0, sync1_q[4]}, sync1_q[3:2], sync1_q[1:0]};

    // A new direction that will be accepted on the next edge is already visible one
    // stage earlier in the synchronizer. A repeat pulse in this cycle is dropped so
    // that it is not immediately followed by the reversal pulse.
    always_comb begin
        ini_next = '0;
        for (int unsigned a = 0; a < 2; a++) begin
            ini_next[a] = (cnt_d[a] == CW'(DEBOUNCE_CYCLES - 1)) &&
                          (samp_next[a] == samp[a]) &&
                          (nivel(samp[a]) != 2'b00) &&
                          (nivel(samp[a]) != nivel(deb_q[a]));
        end
    end

    // Repeat FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned a = 0; a < 2; a++) begin
                st_q[a]   <= IDLE;
                rcnt_q[a] <= '0;
            end
        end else begin
            for (int unsigned a = 0; a < 2; a++) begin
                st_q[a]   <= st_d[a];
                rcnt_q[a] <= rcnt_d[a];
            end
        end
    end

    // Repeat FSM next state: initial pulse, wait REPEAT_DELAY, then every REPEAT_PERIOD
    always_comb begin
        rep_raw = '0;
        for (int unsigned a = 0; a < 2; a++) begin
            st_d[a]   = st_q[a];
            rcnt_d[a] = rcnt_q[a] + RW'(1);
            if (nivel(deb_d[a]) == 2'b00) begin
                st_d[a]   = IDLE;
                rcnt_d[a] = '0;
            end else if (ini[a]) begin
                st_d[a]   = DELAY;
                rcnt_d[a] = '0;
            end else begin
                case (st_q[a])
                    DELAY: begin
                        if (rcnt_q[a] == RW'(REPEAT_DELAY - 1)) begin
                            rep_raw[a] = 1'b1;
                            st_d[a]    = REPEAT;
                            rcnt_d[a]  = '0;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q[a] == RW'(REPEAT_PERIOD - 1)) begin
                            rep_raw[a] = 1'b1;
                            rcnt_d[a]  = '0;
                        end
                    end
                    default: rcnt_d[a] = '0;
                endcase
            end
        end
    end

    // Repeat FSM outputs
    always_comb begin
        rep       = rep_raw & ~ini_next;
        db_estado = {st_q[0], st_q[1]};
    end
`else
    // Without autorepeat each axis pulses only on a change of level
    always_comb begin
        rep       = '0;
        db_estado = '0;
    end
`endif

    // Registered pulses, aligned with the change of the stable outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pv_q <= 1'b0;
            ph_q <= 1'b0;
            pc_q <= 1'b0;
        end else begin
            pv_q <= ini[0] | rep[0];
            ph_q <= ini[1] | rep[1];
            pc_q <= conf_ev;
        end
    end

    assign vertical_estavel   = nivel(deb_q[0]);
    assign horizontal_estavel = nivel(deb_q[1]);
    assign pulso_vertical     = pv_q;
    assign pulso_horizontal   = ph_q;
    assign confirma_pulso     = pc_q;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Self-checking bench for condicionador_entradas with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. The bench follows AUTOREPEAT_EN the same way the RTL does.
module tb_condicionador_entradas;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] cv    = '0;
    logic [1:0] chz   = '0;
    logic       cf    = 1'b0;
    logic [1:0] vertical_estavel, horizontal_estavel;
    logic       pulso_vertical, pulso_horizontal, confirma_pulso;
    logic [3:0] db_estado;

    condicionador_entradas #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .controle_vertical  (cv),
        .controle_horizontal(chz),
        .confirma           (cf),
        .vertical_estavel   (vertical_estavel),
        .horizontal_estavel (horizontal_estavel),
        .pulso_vertical     (pulso_vertical),
        .pulso_horizontal   (pulso_horizontal),
        .confirma_pulso     (confirma_pulso),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. It keeps the raw input history and applies these rules:
    // a channel accepts value v when the D raw samples taken 2..D+1 edges back all equal v.
    // An axis pulses when its level becomes a new non-neutral value.
    // With autorepeat, it pulses again at RD + k*RP edges after that initial pulse.
    logic [4:0] hist [8];
    logic [1:0] m_deb [3];
    logic [1:0] m_out [2];
    logic       m_pul [2];
    logic       m_pc;
    logic [1:0] m_st [2];
    int         cyc;
    int         t_ini [2];

    function automatic logic [1:0] nivel(input logic [1:0] v);
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    function automatic logic [1:0] canal(input logic [4:0] r, input int c);
        case (c)
            0:       return r[1:0];
            1:       return r[3:2];
            default: return {1'b0, r[4]};
        endcase
    endfunction

    function automatic logic janela(input int first, input int c, output logic [1:0] v);
        v = canal(hist[first], c);
        for (int k = first + 1; k < first + D; k++)
            if (canal(hist[k], c) != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) hist[i] = '0;
        for (int c = 0; c < 3; c++) m_deb[c] = '0;
        for (int a = 0; a < 2; a++) begin
            m_out[a] = '0; m_pul[a] = 1'b0; m_st[a] = '0; t_ini[a] = 0;
        end
        m_pc = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] v;
        logic       eq, ini, rep, conf_old;
        logic [1:0] novo;
        int         d;
        cyc++;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {cf, chz, cv};
        conf_old = m_deb[2][0];
        for (int c = 0; c < 3; c++) begin
            eq = janela(2, c, v);
            if (eq && v != m_deb[c]) m_deb[c] = v;
        end
        m_pc = m_deb[2][0] & ~conf_old;
        for (int a = 0; a < 2; a++) begin
            novo = nivel(m_deb[a]);
            ini  = (novo != m_out[a]) && (novo != 2'b00);
            if (ini) t_ini[a] = cyc;
            d        = cyc - t_ini[a];
            rep      = 1'b0;
            m_st[a]  = 2'b00;
            if (AR && novo != 2'b00) begin
                logic [1:0] vn;
                logic       nxt;
                m_st[a] = (d < RD) ? 2'b01 : 2'b10;
                nxt = janela(1, a, vn) && nivel(vn) != 2'b00 && nivel(vn) != novo;
                rep = !ini && d >= RD && ((d - RD) % RP == 0) && !nxt;
            end
            m_pul[a] = ini | rep;
            m_out[a] = novo;
        end
    endtask

    function automatic logic [10:0] dut_bundle();
        return {vertical_estavel, horizontal_estavel, pulso_vertical, pulso_horizontal,
                confirma_pulso, db_estado};
    endfunction

    function automatic logic [10:0] exp_bundle();
        return {m_out[0], m_out[1], m_pul[0], m_pul[1], m_pc, m_st[0], m_st[1]};
    endfunction

    task automatic step();
        @(posedge clock);
        if (reset) model_edge();
        else       model_clear();
        #1;
        check("model", 64'(dut_bundle()), 64'(exp_bundle()));
    endtask

    // Assert reset between clock edges, check the outputs drop at once, then release it.
    task automatic reset_pulse(input int ciclos);
        #2 reset = 1'b0;
        #1 model_clear();
        check("reset_async", 64'(dut_bundle()), 64'd0);
        repeat (ciclos) step();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [1:0] h;
        logic       c;
        logic [1:0] ev;
        logic [1:0] eh;
        int         npv;
        int         nph;
        int         npc;
    } vec_t;

    vec_t tabela [8];

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        npv, nph, npc, n, hold;
        logic [63:0] mask, exp_mask;

        tabela[0] = '{2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1, 0, 0};
        tabela[1] = '{2'b10, 2'b01, 1'b1, 2'b10, 2'b01, 1, 1, 1};
        tabela[2] = '{2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 0, 1, 0};
        tabela[3] = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 1};
        tabela[4] = '{2'b01, 2'b11, 1'b0, 2'b01, 2'b00, 1, 0, 0};
        tabela[5] = '{2'b11, 2'b01, 1'b1, 2'b00, 2'b01, 0, 1, 1};
        tabela[6] = '{2'b10, 2'b10, 1'b0, 2'b10, 2'b10, 1, 1, 0};
        tabela[7] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 0, 0, 0};

        cyc = 0;
        model_clear();
        #1 reset = 1'b0;
        #1 check("reset_state", 64'(dut_bundle()), 64'd0);
        repeat (3) step();
        reset = 1'b1;

        // Table vectors: each record is held 10 cycles
        for (int i = 0; i < 8; i++) begin
            cv = tabela[i].v; chz = tabela[i].h; cf = tabela[i].c;
            npv = 0; nph = 0; npc = 0;
            repeat (10) begin
                step();
                if (pulso_vertical)   npv++;
                if (pulso_horizontal) nph++;
                if (confirma_pulso)   npc++;
            end
            check($sformatf("tab%0d_levels", i), {vertical_estavel, horizontal_estavel},
                  {tabela[i].ev, tabela[i].eh});
            check($sformatf("tab%0d_pulses", i), {8'(npv), 8'(nph), 8'(npc)},
                  {8'(tabela[i].npv), 8'(tabela[i].nph), 8'(tabela[i].npc)});
        end

        // Vertical 00->01: level and single pulse exactly 6 clocks after the change
        cv = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) check("lat_v_before", {vertical_estavel, pulso_vertical}, 3'b000);
            if (k == 6) check("lat_v_at",     {vertical_estavel, pulso_vertical}, 3'b011);
            if (k == 7) check("lat_v_after",  {vertical_estavel, pulso_vertical}, 3'b010);
        end
        cv = 2'b00;
        repeat (8) step();

        // Confirm glitch of 3 clocks, then a real press held for 10 clocks
        cf = 1'b1;
        n  = 0;
        repeat (3) begin step(); if (confirma_pulso) n++; end
        cf = 1'b0;
        repeat (10) begin step(); if (confirma_pulso) n++; end
        check("conf_glitch", n, 0);
        cf = 1'b1;
        n  = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (confirma_pulso) n++;
            if (k == 6) check("conf_press_at6", confirma_pulso, 1'b1);
        end
        check("conf_press_count", n, 1);
        cf = 1'b0;
        n  = 0;
        repeat (10) begin step(); if (confirma_pulso) n++; end
        check("conf_release", n, 0);

        // Horizontal 10 held: repeat pulses at +20, +28, +36, +44, +52 after the initial pulse
        chz = 2'b10;
        repeat (6) step();
        check("rep_h_initial", pulso_horizontal, 1'b1);
        mask = '0;
        for (int j = 1; j <= 59; j++) begin
            step();
            if (pulso_horizontal) mask[j] = 1'b1;
            if (j == 1)  check("rep_h_state_delay",  db_estado[1:0], AR ? 2'b01 : 2'b00);
            if (j == 25) check("rep_h_state_repeat", db_estado[1:0], AR ? 2'b10 : 2'b00);
        end
        exp_mask = AR ? ((64'd1 << 20) | (64'd1 << 28) | (64'd1 << 36) |
                         (64'd1 << 44) | (64'd1 << 52)) : 64'd0;
        check("rep_h_positions", mask, exp_mask);
        check("rep_h_total", 1 + $countones(mask), AR ? 6 : 1);
        chz = 2'b00;
        repeat (8) step();

        // Vertical reversal while repeating: pulse at the new level, next repeat 20 later
        cv = 2'b01;
        repeat (6) step();
        check("rev_initial", pulso_vertical, 1'b1);
        repeat (29) step();
        cv = 2'b10;
        n  = 0;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k <= 25 && pulso_vertical) n++;
            if (k == 6) begin
                check("rev_pulse", {vertical_estavel, pulso_vertical}, 3'b101);
                check("rev_state", db_estado[3:2], AR ? 2'b01 : 2'b00);
            end
            if (k == 26) check("rev_next_repeat", pulso_vertical, AR);
        end
        check("rev_count", n, 1);
        cv = 2'b00;
        repeat (8) step();

        // Reset asserted while a pulse is high
        chz = 2'b01;
        repeat (6) step();
        check("pulse_before_reset", pulso_horizontal, 1'b1);
        reset_pulse(2);

        // Reset during debounce with 11/01/1 held, then full latency after release
        cv = 2'b11; chz = 2'b01; cf = 1'b1;
        repeat (3) step();
        reset_pulse(2);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) check("post_reset_k5", {vertical_estavel, horizontal_estavel, confirma_pulso}, 5'b00000);
            if (k == 6) check("post_reset_k6", {vertical_estavel, horizontal_estavel, confirma_pulso}, 5'b00011);
        end
        cv = 2'b00; chz = 2'b00; cf = 1'b0;
        repeat (10) step();

        // Randomized segments, checked every cycle against the model
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 39) == 0) reset_pulse(int'($urandom_range(1, 3)));
            cv   = 2'($urandom_range(0, 3));
            chz  = 2'($urandom_range(0, 3));
            cf   = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 70)) : int'($urandom_range(1, 9));
            repeat (hold) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
